// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the multiplexed BCD seven-segment scanner.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_ON} state_e;

  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [6:0] SEG_DIGITS [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [2:0] SLOT_MS0  = 3'd0;
  localparam logic [2:0] SLOT_MS1  = 3'd1;
  localparam logic [2:0] SLOT_MS2  = 3'd2;
  localparam logic [2:0] SLOT_S0   = 3'd3;
  localparam logic [2:0] SLOT_S1   = 3'd4;
  localparam logic [2:0] SLOT_MIN0 = 3'd5;
  localparam logic [2:0] SLOT_MIN1 = 3'd6;
  localparam logic [2:0] SLOT_H    = 3'd7;

  // Decimal points separate min.s and s.ms.
  localparam logic [7:0] DP_MASK = 8'b0010_1000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high output.
// Non-decimal codes fall back to a dash so a corrupt digit never shows garbage.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd < 4'd10) seg = SEG_DIGITS[bcd];
  end

endmodule

// File: rtl/bcd_display_scan.sv
// 8-digit time-multiplexed seven-segment scanner with per-frame digit snapshot
// and a dark guard interval per slot. Define BCD_DISP_LZB_EN for leading-zero blanking.
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       NEclk,
  input  logic       reset,
  input  logic       Enable,
  input  logic [3:0] bcd_h,
  input  logic [3:0] bcd_min_1,
  input  logic [3:0] bcd_min_0,
  input  logic [3:0] bcd_s_1,
  input  logic [3:0] bcd_s_0,
  input  logic [3:0] bcd_ms_2,
  input  logic [3:0] bcd_ms_1,
  input  logic [3:0] bcd_ms_0,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  // XOR masks that turn active-high patterns into pin levels.
  localparam logic [7:0] AN_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (ACTIVE_LOW != 0);

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0][3:0]    snap_q, snap_d;
  logic [7:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               frame_done_q, frame_done_d;

  logic               load;
  logic [3:0]         cur_digit;
  logic [6:0]         dec_seg;
  logic               blank;

  // Next-state: slot sequencing and snapshot capture on every slot-0 entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    load    = 1'b0;
    if (!Enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      load    = 1'b1;
      idx_d   = '0;
      cnt_d   = '0;
      state_d = (GUARD == 0) ? ST_ON : ST_GUARD;
    end else if (cnt_q == LAST_C) begin
      load    = (idx_q == SLOT_H);
      idx_d   = idx_q + 3'd1;
      cnt_d   = '0;
      state_d = (GUARD == 0) ? ST_ON : ST_GUARD;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_q == ST_GUARD && cnt_d == GUARD_C) state_d = ST_ON;
    end
    if (load) begin
      snap_d[SLOT_MS0]  = bcd_ms_0;
      snap_d[SLOT_MS1]  = bcd_ms_1;
      snap_d[SLOT_MS2]  = bcd_ms_2;
      snap_d[SLOT_S0]   = bcd_s_0;
      snap_d[SLOT_S1]   = bcd_s_1;
      snap_d[SLOT_MIN0] = bcd_min_0;
      snap_d[SLOT_MIN1] = bcd_min_1;
      snap_d[SLOT_H]    = bcd_h;
    end
  end

  assign cur_digit = snap_d[idx_d];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

`ifdef BCD_DISP_LZB_EN
  assign blank = ((idx_d == SLOT_H) && (snap_d[SLOT_H] == 4'd0)) ||
                 ((idx_d == SLOT_MIN1) && (snap_d[SLOT_H] == 4'd0) &&
                  (snap_d[SLOT_MIN1] == 4'd0));
`else
  assign blank = 1'b0;
`endif

  // Outputs are derived from the next state so they register on the same edge.
  always_comb begin
    logic [7:0] an_act;
    logic [6:0] seg_act;
    logic       dp_act;
    an_act       = '0;
    seg_act      = '0;
    dp_act       = 1'b0;
    frame_done_d = 1'b0;
    if (state_d != ST_IDLE) begin
      seg_act      = blank ? 7'h00 : dec_seg;
      dp_act       = DP_MASK[idx_d];
      frame_done_d = (idx_d == SLOT_H) && (cnt_d == LAST_C);
      if (state_d == ST_ON) an_act = 8'd1 << idx_d;
    end
    an_d  = an_act ^ AN_OFF;
    seg_d = seg_act ^ SEG_OFF;
    dp_d  = dp_act ^ DP_OFF;
  end

  // ---- register stage (falling edge) ----
  always_ff @(negedge NEclk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_q       <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a frame-time reference model and literal pins.
// Honours BCD_DISP_LZB_EN when it is defined for the build.
module tb_bcd_display_scan;

  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;
  localparam int FRAME    = 8 * SCAN_DIV;

  logic       NEclk = 1'b0;
  logic       reset;
  logic       Enable;
  logic [3:0] bcd_h, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0, bcd_ms_2, bcd_ms_1, bcd_ms_0;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;
  logic       frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  bcd_display_scan #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .ACTIVE_LOW(1)) dut (
    .NEclk      (NEclk),
    .reset      (reset),
    .Enable     (Enable),
    .bcd_h      (bcd_h),
    .bcd_min_1  (bcd_min_1),
    .bcd_min_0  (bcd_min_0),
    .bcd_s_1    (bcd_s_1),
    .bcd_s_0    (bcd_s_0),
    .bcd_ms_2   (bcd_ms_2),
    .bcd_ms_1   (bcd_ms_1),
    .bcd_ms_0   (bcd_ms_0),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 NEclk = ~NEclk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Active-high reference glyphs {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: glyph = 7'b0111111;
      4'd1: glyph = 7'b0000110;
      4'd2: glyph = 7'b1011011;
      4'd3: glyph = 7'b1001111;
      4'd4: glyph = 7'b1100110;
      4'd5: glyph = 7'b1101101;
      4'd6: glyph = 7'b1111101;
      4'd7: glyph = 7'b0000111;
      4'd8: glyph = 7'b1111111;
      4'd9: glyph = 7'b1101111;
      default: glyph = 7'b1000000;
    endcase
  endfunction

  // Reference model: position within the frame plus the frame's captured digits.
  bit         m_act = 1'b0;
  int         m_t   = 0;
  logic [3:0] m_snap [8] = '{default: 4'd0};

  always @(negedge NEclk) begin
    if (reset) begin
      m_act  = 1'b0;
      m_t    = 0;
      m_snap = '{default: 4'd0};
    end else if (!Enable) begin
      m_act = 1'b0;
      m_t   = 0;
    end else begin
      if (!m_act) begin
        m_act = 1'b1;
        m_t   = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
      if (m_t == 0) begin
        m_snap[0] = bcd_ms_0;  m_snap[1] = bcd_ms_1;  m_snap[2] = bcd_ms_2;
        m_snap[3] = bcd_s_0;   m_snap[4] = bcd_s_1;   m_snap[5] = bcd_min_0;
        m_snap[6] = bcd_min_1; m_snap[7] = bcd_h;
      end
    end
  end

  always @(posedge NEclk) begin
    if (chk_on) begin
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp, e_fd, blk;
      int slot, ph;
      if (!m_act) begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      end else begin
        slot = m_t / SCAN_DIV;
        ph   = m_t % SCAN_DIV;
        blk  = 1'b0;
`ifdef BCD_DISP_LZB_EN
        if (slot == 7 && m_snap[7] == 0) blk = 1'b1;
        if (slot == 6 && m_snap[7] == 0 && m_snap[6] == 0) blk = 1'b1;
`endif
        e_an  = (ph >= GUARD) ? ~(8'd1 << slot) : 8'hFF;
        e_seg = blk ? 7'h7F : ~glyph(m_snap[slot]);
        e_dp  = !(slot == 3 || slot == 5);
        e_fd  = (m_t == FRAME - 1);
      end
      check("model_an", an, e_an);
      check("model_seg", {1'b0, seg}, {1'b0, e_seg});
      check("model_dp", {7'd0, dp}, {7'd0, e_dp});
      check("model_frame_done", {7'd0, frame_done}, {7'd0, e_fd});
    end
  end

  task automatic set_time(input logic [3:0] h, m1, m0, s1, s0, ms2, ms1, ms0);
    bcd_h = h; bcd_min_1 = m1; bcd_min_0 = m0; bcd_s_1 = s1; bcd_s_0 = s0;
    bcd_ms_2 = ms2; bcd_ms_1 = ms1; bcd_ms_0 = ms0;
  endtask

  task automatic pin(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    check({tag, "_an"}, an, e_an);
    check({tag, "_seg"}, {1'b0, seg}, {1'b0, e_seg});
    check({tag, "_dp"}, {7'd0, dp}, {7'd0, e_dp});
  endtask

  initial begin
    logic [6:0] lz_seg;
`ifdef BCD_DISP_LZB_EN
    lz_seg = 7'h7F;
`else
    lz_seg = 7'h40;
`endif
    reset  = 1'b1;
    Enable = 1'b1;
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8);
    repeat (3) @(posedge NEclk);
    chk_on = 1'b1;
    pin("reset", 8'hFF, 7'h7F, 1'b1);
    check("reset_fd", {7'd0, frame_done}, 8'd0);
    reset = 1'b0;

    @(posedge NEclk); pin("slot0_guard", 8'hFF, 7'h00, 1'b1);
    @(posedge NEclk); pin("slot0_on", 8'hFE, 7'h00, 1'b1);
    repeat (12) @(posedge NEclk); pin("slot3_on", 8'hF7, 7'h12, 1'b0);
    set_time(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2);
    repeat (16) @(posedge NEclk); pin("slot7_old", 8'h7F, 7'h79, 1'b1);
    check("fd_early", {7'd0, frame_done}, 8'd0);
    repeat (2) @(posedge NEclk);
    check("fd_cycle32", {7'd0, frame_done}, 8'd1);
    @(posedge NEclk); pin("new_slot0_guard", 8'hFF, 7'h24, 1'b1);
    check("fd_after", {7'd0, frame_done}, 8'd0);
    @(posedge NEclk); pin("new_slot0_on", 8'hFE, 7'h24, 1'b1);
    bcd_s_0 = 4'hC;

    repeat (44) @(posedge NEclk); pin("dash_slot3", 8'hF7, 7'h3F, 1'b0);
    repeat (4) @(posedge NEclk); pin("slot4_on", 8'hEF, 7'h02, 1'b1);
    Enable = 1'b0;
    @(posedge NEclk); pin("disabled", 8'hFF, 7'h7F, 1'b1);
    check("disabled_fd", {7'd0, frame_done}, 8'd0);
    bcd_s_0  = 4'd5;
    bcd_ms_0 = 4'd0;
    repeat (40) @(posedge NEclk); pin("still_dark", 8'hFF, 7'h7F, 1'b1);
    Enable = 1'b1;
    @(posedge NEclk); pin("reen_guard", 8'hFF, 7'h40, 1'b1);
    @(posedge NEclk); pin("reen_on", 8'hFE, 7'h40, 1'b1);

    repeat (28) @(posedge NEclk); pin("slot7_nine", 8'h7F, 7'h10, 1'b1);
    set_time(4'd0, 4'd0, 4'd5, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8);
    reset = 1'b1;
    @(posedge NEclk); pin("midframe_reset", 8'hFF, 7'h7F, 1'b1);
    check("midframe_reset_fd", {7'd0, frame_done}, 8'd0);
    reset = 1'b0;

    repeat (22) @(posedge NEclk); pin("lz_slot5", 8'hDF, 7'h12, 1'b0);
    repeat (4) @(posedge NEclk); pin("lz_slot6", 8'hBF, lz_seg, 1'b1);
    repeat (4) @(posedge NEclk); pin("lz_slot7", 8'h7F, lz_seg, 1'b1);
    repeat (2) @(posedge NEclk);
    check("lz_fd", {7'd0, frame_done}, 8'd1);
    repeat (3) @(posedge NEclk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
